// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the mult_divider block:
//   DATA_W    - operand / result width (64)
//   REM_W     - width of the shifted partial remainder used by a trial step
//   state_t   - controller states IDLE, CALC, DONE
//   cnt_width - iteration counter width for a given BITS_PER_CYCLE
// -----------------------------------------------------------------------------
package mult_div_pkg;

   localparam int DATA_W = 64;
   localparam int REM_W  = DATA_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter has to reach DATA_W/bits_per_cycle - 1; keep at least one bit.
   function automatic int cnt_width(input int bits_per_cycle);
      int steps;
      steps = DATA_W / bits_per_cycle;
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the partial remainder left
// by one, bringing in the next dividend bit, trial-subtract the divisor and
// keep the difference only when it does not go negative.
// Ports:
//   i_rem      - partial remainder entering the step (always < divisor)
//   i_dvd_bit  - next dividend bit, MSB first
//   i_divisor  - divisor
//   o_rem      - partial remainder leaving the step
//   o_q_bit    - quotient bit retired by this step
// -----------------------------------------------------------------------------
module div_step
   import mult_div_pkg::*;
(
   input  logic [DATA_W-1:0] i_rem,
   input  logic              i_dvd_bit,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [DATA_W-1:0] o_rem,
   output logic              o_q_bit
);

   logic [REM_W-1:0]  w_shift;
   logic [DATA_W-1:0] w_diff;
   logic              w_ge;

   // The shifted value can exceed 64 bits, so the trial compare is done on
   // the full 65-bit value. Whenever the difference is selected it is below
   // the divisor, so its low 64 bits are exact.
   assign w_shift = {i_rem, i_dvd_bit};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   assign w_diff  = w_shift[DATA_W-1:0] - i_divisor;

   assign o_rem   = w_ge ? w_diff : w_shift[DATA_W-1:0];
   assign o_q_bit = w_ge;

endmodule

// File: rtl/mult_divider.sv
// -----------------------------------------------------------------------------
// mult_divider
// Iterative unsigned 64-bit restoring divider retiring BITS_PER_CYCLE quotient
// bits per clock (legal values 1, 2, 4, 8).
// Optional feature macro: MULT_DIVIDER_EARLY_OUT_EN
//   When defined, a request with divisor 0 or dividend < divisor skips the
//   iteration and completes in the cycle after acceptance.
// Handshake: start is sampled on a rising edge only while busy is low
//   (state IDLE or DONE). done pulses for one cycle per completed request;
//   quotient, remainder and div_by_zero are valid with it and hold until the
//   next completion. busy is high only while iterating.
// Ports:
//   clock        - clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - request
//   dividend     - numerator, captured on acceptance
//   divisor      - denominator, captured on acceptance
//   quotient     - result quotient (all ones for divisor 0)
//   remainder    - result remainder (dividend for divisor 0)
//   busy         - high while in CALC
//   done         - one-cycle completion pulse
//   div_by_zero  - completed request had divisor 0
//   o_dbg_state  - current controller state
// -----------------------------------------------------------------------------
module mult_divider
   import mult_div_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output state_t            o_dbg_state
);

   localparam int               STEPS    = DATA_W / BITS_PER_CYCLE;
   localparam int               CNT_W    = cnt_width(BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0]  r_cnt;
   // r_acc starts as the dividend; each cycle the consumed dividend bits leave
   // at the top while the new quotient bits enter at the bottom, so after the
   // last step it holds the full quotient.
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvs;
   logic [DATA_W-1:0] r_quotient;
   logic [DATA_W-1:0] r_remainder;
   logic              r_dbz;

   logic                      w_accept;
   logic                      w_last;
   logic                      w_early;
   logic [DATA_W-1:0]         w_rem [0:BITS_PER_CYCLE];
   logic [BITS_PER_CYCLE-1:0] w_qbits;
   logic [DATA_W-1:0]         w_acc_nxt;

   // ---------------------------------------------------------------------
   // Step chain: step i consumes dividend bit 63-i of r_acc, MSB first.
   // ---------------------------------------------------------------------
   assign w_rem[0] = r_rem;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      div_step u_div_step (
         .i_rem     (w_rem[i]),
         .i_dvd_bit (r_acc[DATA_W-1-i]),
         .i_divisor (r_dvs),
         .o_rem     (w_rem[i+1]),
         .o_q_bit   (w_qbits[BITS_PER_CYCLE-1-i])
      );
   end

   assign w_acc_nxt = {r_acc[DATA_W-1-BITS_PER_CYCLE:0], w_qbits};

`ifdef MULT_DIVIDER_EARLY_OUT_EN
   assign w_early = (divisor == '0) || (dividend < divisor);
`else
   assign w_early = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Controller: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Controller: next state. DONE behaves like IDLE for acceptance so a
   // request held across done starts without a bubble.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = w_early ? DONE : CALC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CALC: begin
            if (r_cnt == LAST_CNT) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath. Result registers only load on completion, so they stay
   // stable while the next request iterates.
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_rem       <= '0;
         r_dvs       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_acc <= dividend;
         r_rem <= '0;
         r_dvs <= divisor;
         if (w_early) begin
            r_quotient  <= (divisor == '0) ? '1 : '0;
            r_remainder <= dividend;
            r_dbz       <= (divisor == '0);
         end
      end else if (r_state == CALC) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_acc_nxt;
         r_rem <= w_rem[BITS_PER_CYCLE];
         if (w_last) begin
            r_quotient  <= w_acc_nxt;
            r_remainder <= w_rem[BITS_PER_CYCLE];
            r_dbz       <= (r_dvs == '0);
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   assign busy        = (r_state == CALC);
   assign done        = (r_state == DONE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_divider.sv
// -----------------------------------------------------------------------------
// tb_mult_divider
// Bench for mult_divider: a default-width instance checked every cycle
// against a cycle-level reference model, plus three instances with
// BITS_PER_CYCLE 1, 2 and 8 for the all-ones / 1 latency cases.
// Honours MULT_DIVIDER_EARLY_OUT_EN when it is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_divider;
   import mult_div_pkg::*;

   localparam int MAIN_LAT = 17;
`ifdef MULT_DIVIDER_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // ---------------- main DUT ----------------
   logic        start    = 1'b0;
   logic [63:0] dividend = '0;
   logic [63:0] divisor  = '0;
   logic [63:0] quotient, remainder;
   logic        busy, done, div_by_zero;
   state_t      dbg_state;

   mult_divider #(.BITS_PER_CYCLE(4)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .o_dbg_state (dbg_state)
   );

   // ---------------- alternate-width DUTs ----------------
   logic        x_start    = 1'b0;
   logic [63:0] x_dividend = '0;
   logic [63:0] x_divisor  = '0;
   logic [63:0] x_q [3];
   logic [63:0] x_r [3];
   logic        x_busy [3];
   logic        x_done [3];
   logic        x_dbz [3];
   state_t      x_st [3];

   for (genvar g = 0; g < 3; g++) begin : g_alt
      localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
      mult_divider #(.BITS_PER_CYCLE(BPC)) u_alt (
         .clock       (clock),
         .reset       (reset),
         .start       (x_start),
         .dividend    (x_dividend),
         .divisor     (x_divisor),
         .quotient    (x_q[g]),
         .remainder   (x_r[g]),
         .busy        (x_busy[g]),
         .done        (x_done[g]),
         .div_by_zero (x_dbz[g]),
         .o_dbg_state (x_st[g])
      );
   end

   // ---------------- counters / check helpers ----------------
   int checks = 0;
   int errors = 0;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Result record layout: {div_by_zero, quotient, remainder}.
   function automatic logic [128:0] ref_div(input logic [63:0] a, input logic [63:0] b);
      if (b == 64'd0) return {1'b1, {64{1'b1}}, a};
      return {1'b0, a / b, a % b};
   endfunction

   // Cycles from the cycle start is accepted to the cycle done is high.
   function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b);
      return (EARLY_OUT && ((b == 64'd0) || (a < b))) ? 1 : MAIN_LAT;
   endfunction

   logic [128:0] exp_q[$];
   int           m_edge      = 0;
   bit           m_pending   = 1'b0;
   int           m_done_edge = 0;
   logic [63:0]  m_q = '0;
   logic [63:0]  m_r = '0;
   logic         m_dbz  = 1'b0;
   logic         m_done = 1'b0;
   logic         m_busy = 1'b0;

   // A request accepted at edge e shows done right after edge e+lat-1; the
   // unit is free to accept at any edge after the one that raised done.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pending = 1'b0;
         exp_q.delete();
         m_q    = '0;
         m_r    = '0;
         m_dbz  = 1'b0;
         m_done = 1'b0;
         m_busy = 1'b0;
      end else begin
         m_edge++;
         if (start && !(m_pending && (m_edge <= m_done_edge))) begin
            exp_q.push_back(ref_div(dividend, divisor));
            m_pending   = 1'b1;
            m_done_edge = m_edge + ref_lat(dividend, divisor) - 1;
         end
         m_done = m_pending && (m_edge == m_done_edge);
         m_busy = m_pending && (m_edge < m_done_edge);
         if (m_done && (exp_q.size() > 0)) {m_dbz, m_q, m_r} = exp_q.pop_front();
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;
   always @(negedge clock) begin
      if (cmp_en && reset) begin
         check1 ("cyc busy",        busy,        m_busy);
         check1 ("cyc done",        done,        m_done);
         check64("cyc quotient",    quotient,    m_q);
         check64("cyc remainder",   remainder,   m_r);
         check1 ("cyc div_by_zero", div_by_zero, m_dbz);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_req(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                          input int elat);
      int lat;
      bit seen;
      @(negedge clock);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      lat  = 0;
      seen = 1'b0;
      while (!seen && (lat < 100)) begin
         @(negedge clock);
         start = 1'b0;
         lat++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      end else begin
         check64({name, " latency"}, 64'(lat), 64'(elat));
         check64({name, " quotient"}, quotient, eq);
         check64({name, " remainder"}, remainder, er);
         check1 ({name, " div_by_zero"}, div_by_zero, edbz);
      end
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'd1;
         2:       return {64{1'b1}};
         3:       return {32'd0, $urandom};
         4:       return 64'($urandom_range(0, 255));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // ---------------- main sequence ----------------
   int           alt_lat [3];
   int           alt_exp [3];
   int           t1;
   int           t2;
   logic [63:0]  q1;
   logic [63:0]  r1;
   logic [63:0]  ra;
   logic [63:0]  rb;
   logic [128:0] rres;
   int           lat;
   bit           seen;
   bit           late_done;

   initial begin
      alt_exp = '{65, 33, 9};

      // reset state
      repeat (3) @(negedge clock);
      #1;
      check64("reset quotient",  quotient,  64'd0);
      check64("reset remainder", remainder, 64'd0);
      check1 ("reset busy",      busy,      1'b0);
      check1 ("reset done",      done,      1'b0);
      check1 ("reset dbz",       div_by_zero, 1'b0);
      check64("reset state",     64'(dbg_state), 64'(IDLE));
      #1 reset = 1'b1;
      cmp_en = 1'b1;

      // basic directed vectors
      run_req("100/7",   64'd100, 64'd7, 64'd14, 64'd2, 1'b0, MAIN_LAT);
      run_req("max/1",   {64{1'b1}}, 64'd1, {64{1'b1}}, 64'd0, 1'b0, MAIN_LAT);
      run_req("5/0",     64'd5, 64'd0, {64{1'b1}}, 64'd5, 1'b1, EARLY_OUT ? 1 : MAIN_LAT);
      run_req("3/10",    64'd3, 64'd10, 64'd0, 64'd3, 1'b0, EARLY_OUT ? 1 : MAIN_LAT);
      run_req("max/max", {64{1'b1}}, {64{1'b1}}, 64'd1, 64'd0, 1'b0, MAIN_LAT);
      run_req("max/2^63", {64{1'b1}}, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, MAIN_LAT);

      // back-to-back: start held across done, operands change during CALC
      @(negedge clock);
      start = 1'b1; dividend = 64'd100; divisor = 64'd7;
      @(negedge clock);
      dividend = 64'd9; divisor = 64'd3;
      t1 = 0; t2 = 0; q1 = '0; r1 = '0;
      for (int k = 1; k <= 60; k++) begin
         if (t2 == 0) begin
            @(negedge clock);
            if ((t1 != 0) && (k == t1 + 1)) start = 1'b0;
            if (done) begin
               if (t1 == 0) begin
                  t1 = k + 1;
                  q1 = quotient;
                  r1 = remainder;
               end else begin
                  t2 = k + 1;
               end
            end
         end
      end
      start = 1'b0;
      check64("b2b first latency",  64'(t1), 64'd17);
      check64("b2b first quotient", q1, 64'd14);
      check64("b2b first remainder", r1, 64'd2);
      check64("b2b spacing", 64'(t2 - t1), 64'd17);
      check64("b2b second quotient",  quotient,  64'd3);
      check64("b2b second remainder", remainder, 64'd0);

      // start pulses with other operands during CALC are ignored
      @(negedge clock);
      start = 1'b1; dividend = 64'd200; divisor = 64'd9;
      lat = 0; seen = 1'b0;
      while (!seen && (lat < 40)) begin
         @(negedge clock);
         lat++;
         if ((lat == 3) || (lat == 8)) begin
            start = 1'b1; dividend = 64'd1; divisor = 64'd1;
         end else begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check64("pulse latency",   64'(lat), 64'd17);
      check64("pulse quotient",  quotient, 64'd22);
      check64("pulse remainder", remainder, 64'd2);

      // reset five cycles into CALC
      run_req("17/5", 64'd17, 64'd5, 64'd3, 64'd2, 1'b0, MAIN_LAT);
      @(negedge clock);
      start = 1'b1; dividend = 64'd50; divisor = 64'd7;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check64("abort quotient",  quotient,  64'd0);
      check64("abort remainder", remainder, 64'd0);
      check1 ("abort busy",      busy,      1'b0);
      check1 ("abort done",      done,      1'b0);
      check1 ("abort dbz",       div_by_zero, 1'b0);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      late_done = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (done) late_done = 1'b1;
      end
      check1("abort no done", late_done, 1'b0);
      run_req("10/4", 64'd10, 64'd4, 64'd2, 64'd2, 1'b0, MAIN_LAT);

      // alternate widths: all ones / 1
      @(negedge clock);
      x_start = 1'b1; x_dividend = {64{1'b1}}; x_divisor = 64'd1;
      alt_lat = '{0, 0, 0};
      for (int k = 1; k <= 80; k++) begin
         @(negedge clock);
         x_start = 1'b0;
         for (int g = 0; g < 3; g++) begin
            if (x_done[g] && (alt_lat[g] == 0)) alt_lat[g] = k;
         end
      end
      for (int g = 0; g < 3; g++) begin
         check64($sformatf("alt%0d latency", g), 64'(alt_lat[g]), 64'(alt_exp[g]));
         check64($sformatf("alt%0d quotient", g), x_q[g], {64{1'b1}});
         check64($sformatf("alt%0d remainder", g), x_r[g], 64'd0);
         check1 ($sformatf("alt%0d dbz", g), x_dbz[g], 1'b0);
         check1 ($sformatf("alt%0d busy", g), x_busy[g], 1'b0);
         check64($sformatf("alt%0d state", g), 64'(x_st[g]), 64'(IDLE));
      end

      // random operands including 0, 1 and max
      for (int n = 0; n < 1000; n++) begin
         ra   = pick_operand();
         rb   = pick_operand();
         rres = ref_div(ra, rb);
         run_req("random", ra, rb, rres[127:64], rres[63:0], rres[128], ref_lat(ra, rb));
      end

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
